// File: rtl/des_lincrypt_block.sv
// Iterative reduced-round DES engine that streams LFSR plaintexts through ROUNDS
// rounds and counts pairs where the linear approximation evaluates to zero.
`timescale 1ns/1ps

module des_lincrypt_block #(
  parameter int ROUNDS = 6
) (
  input  logic         clk,
  // Active-high despite the name; the wrapper already drives it this way.
  input  logic         rst_n,
  input  logic         start,
  input  logic         restart_block,
  input  logic [63:0]  seed,
  input  logic [63:0]  polynomial,
  input  logic [63:0]  mask_i,
  input  logic [63:0]  mask_o,
  input  logic [63:0]  counter_limit,
  input  logic [767:0] round_keys,
  output logic [63:0]  counter,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, ROUND, CHECK, DONE} state_t;

  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Each box is indexed by {row, column} = {b1, b6, b2..b5}.
  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  state_t       state, state_next;
  logic [63:0]  lfsr, lfsr_next;
  logic [63:0]  data;
  logic [63:0]  ptext;
  logic [63:0]  limit;
  logic [63:0]  processed;
  logic [4:0]   round_idx;
  logic         run_load, round_en, check_en;
  logic         last_round, last_pt, approx;
  logic [47:0]  sub_key [16];
  logic [47:0]  e_out, s_in;
  logic [31:0]  s_out, f_out;
  logic [63:0]  round_out;

  assign last_round = (round_idx == 5'(ROUNDS - 1));
  assign last_pt    = (processed + 64'd1 == limit);

  // ---------------------------------------------------------------- FSM
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = (counter_limit == 64'd0) ? DONE : ROUND;
      ROUND:      if (last_round) state_next = CHECK;
      CHECK:      state_next = last_pt ? DONE : ROUND;
      default:    state_next = IDLE;
    endcase
    if (restart_block) state_next = IDLE;
  end

  always_comb begin
    run_load = 1'b0;
    round_en = 1'b0;
    check_en = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  run_load = start;
      ROUND: round_en = 1'b1;
      CHECK: check_en = 1'b1;
      DONE: begin
        run_load = start;
        done     = 1'b1;
      end
      default: ;
    endcase
    if (restart_block) begin
      run_load = 1'b0;
      round_en = 1'b0;
      check_en = 1'b0;
    end
  end

  // ---------------------------------------------------------------- round function
  for (genvar r = 0; r < 16; r++) begin : g_key
    assign sub_key[r] = round_keys[767 - 48*r -: 48];
  end

  // data[31:0] is R; DES bit n (1 = MSB) of a W-bit word sits at index W-n.
  for (genvar j = 0; j < 48; j++) begin : g_expand
    assign e_out[47 - j] = data[32 - E_TAB[j]];
  end

  assign s_in = e_out ^ sub_key[round_idx[3:0]];

  for (genvar i = 0; i < 8; i++) begin : g_sbox
    logic [5:0] six;
    assign six = s_in[47 - 6*i -: 6];
    assign s_out[31 - 4*i -: 4] = 4'(SBOX[i][{six[5], six[0], six[4:1]}]);
  end

  for (genvar j = 0; j < 32; j++) begin : g_perm
    assign f_out[31 - j] = s_out[32 - P_TAB[j]];
  end

  assign round_out = {data[31:0], data[63:32] ^ f_out};
  assign approx    = (^(ptext & mask_i)) ^ (^(data & mask_o));
  assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? polynomial : 64'd0);

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      lfsr      <= '0;
      data      <= '0;
      ptext     <= '0;
      limit     <= '0;
      processed <= '0;
      round_idx <= '0;
      counter   <= '0;
    end else begin
      if (run_load) begin
        lfsr      <= seed;
        data      <= seed;
        ptext     <= seed;
        limit     <= counter_limit;
        processed <= '0;
        round_idx <= '0;
        counter   <= '0;
      end else if (round_en) begin
        data      <= round_out;
        round_idx <= round_idx + 5'd1;
      end else if (check_en) begin
        if (!approx) counter <= counter + 64'd1;
        lfsr      <= lfsr_next;
        data      <= lfsr_next;
        ptext     <= lfsr_next;
        processed <= processed + 64'd1;
        round_idx <= '0;
      end
      if (restart_block) counter <= '0;
    end
  end

endmodule

// File: tb/tb_des_lincrypt_block.sv
// Scoreboard bench for des_lincrypt_block: three instances (1, 6 and 16 rounds)
// share stimulus; expected counts and latencies are queued at start and checked at done.
`timescale 1ns/1ps

module tb_des_lincrypt_block;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         restart_block = 1'b0;
  logic [63:0]  seed = '0, polynomial = '0, mask_i = '0, mask_o = '0, counter_limit = '0;
  logic [767:0] round_keys = '0;
  logic [63:0]  counter_r1, counter_r6, counter_r16;
  logic         done_r1, done_r6, done_r16;

  always #5 clk = ~clk;

  des_lincrypt_block #(.ROUNDS(1)) dut_r1 (
    .clk(clk), .rst_n(rst_n), .start(start), .restart_block(restart_block),
    .seed(seed), .polynomial(polynomial), .mask_i(mask_i), .mask_o(mask_o),
    .counter_limit(counter_limit), .round_keys(round_keys),
    .counter(counter_r1), .done(done_r1));

  des_lincrypt_block #(.ROUNDS(6)) dut_r6 (
    .clk(clk), .rst_n(rst_n), .start(start), .restart_block(restart_block),
    .seed(seed), .polynomial(polynomial), .mask_i(mask_i), .mask_o(mask_o),
    .counter_limit(counter_limit), .round_keys(round_keys),
    .counter(counter_r6), .done(done_r6));

  des_lincrypt_block #(.ROUNDS(16)) dut_r16 (
    .clk(clk), .rst_n(rst_n), .start(start), .restart_block(restart_block),
    .seed(seed), .polynomial(polynomial), .mask_i(mask_i), .mask_o(mask_o),
    .counter_limit(counter_limit), .round_keys(round_keys),
    .counter(counter_r16), .done(done_r16));

  localparam int UNIT_ROUNDS [3] = '{1, 6, 16};

  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct {
    string       tag;
    int          unit;
    logic [63:0] cnt;
    int          lat;
  } exp_t;

  exp_t sb [$];
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic logic [63:0] cnt_of(input int u);
    case (u)
      0:       return counter_r1;
      1:       return counter_r6;
      default: return counter_r16;
    endcase
  endfunction

  function automatic logic done_of(input int u);
    case (u)
      0:       return done_r1;
      1:       return done_r6;
      default: return done_r16;
    endcase
  endfunction

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y = '0;
    for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IP_TAB[j])];
    return y;
  endfunction

  function automatic logic [767:0] key_sched(input logic [63:0] key);
    logic [767:0] ks = '0;
    logic [55:0]  cd = '0;
    logic [27:0]  c, d;
    logic [47:0]  k = '0;
    for (int j = 0; j < 56; j++) cd[6'(55 - j)] = key[6'(64 - PC1_TAB[j])];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) k[6'(47 - j)] = cd[6'(56 - PC2_TAB[j])];
      ks = {ks[719:0], k};
    end
    return ks;
  endfunction

  // Count of plaintexts with even parity under mask, for mask_o = 0.
  function automatic logic [63:0] lfsr_count(input logic [63:0] s0, input logic [63:0] poly,
                                             input logic [63:0] mi, input int n);
    logic [63:0] s = s0;
    logic [63:0] cnt = '0;
    for (int i = 0; i < n; i++) begin
      if (^(s & mi) == 1'b0) cnt++;
      s = (s >> 1) ^ (s[0] ? poly : 64'd0);
    end
    return cnt;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input int unit, input logic [63:0] cnt, input int lat);
    exp_t e;
    e.tag  = tag;
    e.unit = unit;
    e.cnt  = cnt;
    e.lat  = lat;
    sb.push_back(e);
  endtask

  task automatic expect_all(input string tag, input logic [63:0] cnt, input int n);
    for (int u = 0; u < 3; u++)
      push($sformatf("%s_r%0d", tag, UNIT_ROUNDS[u]), u, cnt, n * (UNIT_ROUNDS[u] + 1));
  endtask

  // Pulse start (held for 'hold' extra cycles), wait for all units, then drain the scoreboard.
  task automatic run(input int budget, input int hold);
    int   done_at [3];
    exp_t e;
    done_at = '{-1, -1, -1};
    start = 1'b1;
    tick();
    for (int c = 0; c <= budget; c++) begin
      if (c >= hold) start = 1'b0;
      for (int u = 0; u < 3; u++)
        if (done_at[u] < 0 && done_of(u)) done_at[u] = c;
      if (done_at[0] >= 0 && done_at[1] >= 0 && done_at[2] >= 0) break;
      tick();
    end
    start = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, "_latency"}, 64'(done_at[e.unit]), 64'(e.lat));
      check({e.tag, "_counter"}, cnt_of(e.unit), e.cnt);
    end
  endtask

  initial begin
    logic [63:0] c_exp, t;

    // Reset state
    tick();
    tick();
    for (int u = 0; u < 3; u++) begin
      check($sformatf("reset_counter_u%0d", u), cnt_of(u), 64'd0);
      check($sformatf("reset_done_u%0d", u), 64'(done_of(u)), 64'd0);
    end
    rst_n = 1'b0;
    tick();

    // Zero masks: every pair satisfies the approximation
    seed          = 64'h149151654114612;
    polynomial    = 64'd1;
    counter_limit = 64'd9;
    expect_all("zero_mask", 64'd9, 9);
    run(9 * 17 + 5, 0);
    repeat (8) tick();
    check("freeze_counter", counter_r6, 64'd9);
    check("freeze_done", 64'(done_r6), 64'd1);

    // One round: L1 = R0, so P bit 0 always equals C bit 32
    mask_i = 64'h1;
    mask_o = 64'h1_0000_0000;
    for (int w = 0; w < 24; w++) round_keys = {round_keys[735:0], 32'($urandom())};
    seed          = {32'($urandom()), 32'($urandom())};
    polynomial    = {32'($urandom()), 32'($urandom())};
    counter_limit = 64'd20;
    push("l1_eq_r0", 0, 64'd20, 40);
    run(20 * 17 + 5, 0);

    // Plain shift LFSR: plaintexts 2, 1, 0
    seed          = 64'h2;
    polynomial    = 64'h0;
    mask_i        = 64'h1;
    mask_o        = 64'h0;
    counter_limit = 64'd3;
    expect_all("lfsr_shift", 64'd2, 3);
    run(3 * 17 + 5, 0);

    // Galois LFSR with random taps, counted by the bench model
    seed          = {32'($urandom()), 32'($urandom())};
    polynomial    = {32'($urandom()), 32'($urandom())} | 64'h8000_0000_0000_0000;
    mask_i        = {32'($urandom()), 32'($urandom())};
    counter_limit = 64'd25;
    expect_all("lfsr_galois", lfsr_count(seed, polynomial, mask_i, 25), 25);
    run(25 * 17 + 5, 0);

    // Zero-length run
    counter_limit = 64'd0;
    expect_all("limit_zero", 64'd0, 0);
    run(5, 0);

    // restart_block mid-run, with a simultaneous start that must be ignored
    mask_i        = 64'h0;
    polynomial    = 64'd1;
    seed          = 64'h149151654114612;
    counter_limit = 64'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    restart_block = 1'b1;
    start         = 1'b1;
    tick();
    restart_block = 1'b0;
    start         = 1'b0;
    for (int u = 0; u < 3; u++) begin
      check($sformatf("restart_counter_u%0d", u), cnt_of(u), 64'd0);
      check($sformatf("restart_done_u%0d", u), 64'(done_of(u)), 64'd0);
    end
    repeat (10) tick();
    check("restart_idle_counter", counter_r6, 64'd0);
    check("restart_idle_done", 64'(done_r6), 64'd0);
    expect_all("after_restart", 64'd9, 9);
    run(9 * 17 + 5, 0);

    // start held high through ROUND/CHECK cycles has no effect
    expect_all("start_held", 64'd9, 9);
    run(9 * 17 + 5, 10);

    // Asynchronous reset mid-run
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    rst_n = 1'b1;
    #1;
    for (int u = 0; u < 3; u++) begin
      check($sformatf("async_reset_counter_u%0d", u), cnt_of(u), 64'd0);
      check($sformatf("async_reset_done_u%0d", u), 64'(done_of(u)), 64'd0);
    end
    tick();
    rst_n = 1'b0;
    tick();

    // Known answer, 16 rounds: probe each ciphertext bit with a one-hot mask_o
    round_keys    = key_sched(64'h133457799BBCDFF1);
    seed          = ip(64'h0123456789ABCDEF);
    polynomial    = 64'h0;
    mask_i        = 64'h0;
    counter_limit = 64'd1;
    t     = ip(64'h85E813540F0AB405);
    c_exp = {t[31:0], t[63:32]};
    for (int b = 0; b < 64; b++) begin
      mask_o = 64'd1 << b;
      push($sformatf("kat_bit%0d", b), 2, ((c_exp >> b) & 64'd1) ^ 64'd1, 17);
      run(25, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/des_lincrypt_block.md
# des_lincrypt_block

Iterative reduced-round DES core for linear-cryptanalysis experiments. After a start pulse it generates `counter_limit` plaintexts from a Galois LFSR and encrypts each one through a parameterised number of DES rounds. For each plaintext/ciphertext pair it evaluates the linear approximation parity(P & mask_i) ^ parity(C & mask_o) and counts the pairs where the result is 0. Several instances sit side by side under an AXI wrapper, which programs the inputs and reads back `counter` and `done`.

## Interface
- ROUNDS, 6: DES rounds per encryption, legal range 1..16.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-high reset (asserted = 1).
- start  input  1  one-cycle pulse; honoured only in IDLE or DONE.
- restart_block  input  1  synchronous abort/clear; takes priority over start.
- seed  input  64  initial LFSR state = first plaintext.
- polynomial  input  64  Galois feedback taps.
- mask_i  input  64  input mask, applied to plaintext L0||R0.
- mask_o  input  64  output mask, applied to ciphertext Ln||Rn.
- counter_limit  input  64  number of plaintexts to process.
- round_keys  input  768  48-bit subkey for round r (1-based) is round_keys[767-48*(r-1) -: 48]. Unused low bits are ignored.
- counter  output  64  running count of pairs with approximation = 0.
- done  output  1  high when the run is complete.

## Operation
- FSM states and transitions:
  - IDLE --start--> ROUND. If counter_limit == 0, start goes straight to DONE.
  - ROUND runs ROUNDS cycles, then moves to CHECK.
  - CHECK goes to ROUND if more plaintexts remain, otherwise to DONE.
  - DONE --start--> new run, with the same rules as from IDLE.
- On start: latch seed into the LFSR and into the data register, latch counter_limit, clear counter, clear the processed count and the round index, and drop done.
- No IP or FP is applied. Plaintext bits [63:32] = L0 and [31:0] = R0.
- Each round: L' = R, R' = L ^ f(R, K_r), where f is FIPS 46-3 E-expansion, XOR with the subkey, S1..S8, then P.
- The ciphertext is C = L_n||R_n, with no final swap.
- CHECK cycle:
  - bit = ^(P & mask_i) ^ ^(C & mask_o); if bit == 0, counter increments by 1.
  - LFSR steps: next = (s >> 1) ^ (s[0] ? polynomial : 0).
  - The data register reloads with the new LFSR state.
  - The processed count increments.
- The plaintext is the LFSR state before stepping. It is held in a dedicated register during the rounds.
- counter is 64-bit and wraps modulo 2^64; this is not reachable in practice.
- mask_i, mask_o, polynomial and round_keys are used live. They must be held stable from start until done. Changes mid-run are undefined by design.
- restart_block (any state): go to IDLE, clear counter and done. This is synchronous. If start is also high in the same cycle, start is ignored.
- start during ROUND or CHECK is ignored.

## Timing
- Reset values: state IDLE, counter 0, done 0, LFSR 0, all internal registers 0.
- Each plaintext takes ROUNDS + 1 cycles.
- With start sampled at edge t0 and N = counter_limit:
  - done is 1 after edge t0 + N*(ROUNDS+1).
  - For N = 0, done is 1 after edge t0 itself.
- counter is registered. It reflects each CHECK after that edge and is final once done = 1.
- done stays high and counter stays frozen until start, restart_block or reset.
- Asynchronous reset mid-run aborts immediately to the reset values.

## Test plan
- Zero masks, ROUNDS=6, seed=64'h149151654114612, polynomial=1, counter_limit=9, round_keys=0, start pulse -> done high after 63 cycles, counter=9.
- ROUNDS=1, mask_i=64'h1, mask_o=64'h1_0000_0000, random keys and seed, counter_limit=20 -> counter=20, because L1 = R0.
- seed=64'h2, polynomial=0, mask_i=64'h1, mask_o=0, counter_limit=3 -> plaintexts 2, 1, 0; counter=2; done after 3*(ROUNDS+1) cycles.
- counter_limit=0, start -> done=1 one edge later, counter=0.
- restart_block pulsed mid-run (limit=9) -> next cycle done=0, counter=0, IDLE. A following start runs to completion normally.
- Reset asserted mid-run -> counter=0 and done=0 immediately. start held during ROUND has no effect.
- Known-answer: ROUNDS=16, subkeys derived from DES key 64'h133457799BBCDFF1, and plaintext 64'h0123456789ABCDEF after IP applied in software. The result C, with R16||L16 swapped and FP applied in software, must equal 64'h85E813540F0AB405.
